// File: rtl/debounce_pkg.sv
// Shared types, timing defaults and width helper for the button debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      SETTLE_PRESS   = 2'd1,
      HELD           = 2'd2,
      SETTLE_RELEASE = 2'd3
   } state_t;

   // Board-clock defaults: 1 ms settle, 100 ms first repeat, 50 ms repeat rate at 50 MHz.
   localparam logic [15:0] DEF_SETTLE_CYCLES = 16'd50000;
   localparam logic [23:0] DEF_REPEAT_DELAY  = 24'd5000000;
   localparam logic [23:0] DEF_REPEAT_PERIOD = 24'd2500000;

   // Bits needed for a counter that must hold values 0..max_count.
   function automatic int cnt_width(input int max_count);
      if (max_count < 1) return 1;
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   // Capture the raw input, then re-time it once more before use.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, settle-filter, press/release strobes,
// optional hold-to-repeat.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE           | released and settled, waiting for a synchronised 1
// SETTLE_PRESS   | counting consecutive 1 samples before accepting the press
// HELD           | press accepted; hold counter drives auto-repeat
// SETTLE_RELEASE | counting consecutive 0 samples; hold counter frozen
module button_debouncer
   import debounce_pkg::*;
#(
   parameter logic [15:0] settle_cycles = DEF_SETTLE_CYCLES,
   parameter logic [23:0] repeat_delay  = DEF_REPEAT_DELAY,
   parameter logic [23:0] repeat_period = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   input  logic repeat_enable,
   output logic strobe,
   output logic release_strobe,
   output logic pressed
);

   localparam int SETTLE_W = cnt_width(int'(settle_cycles));
   localparam int HOLD_MAX = (repeat_delay > repeat_period) ? int'(repeat_delay)
                                                             : int'(repeat_period);
   localparam int HOLD_W   = cnt_width(HOLD_MAX);

   // The count holds samples already seen, so the current sample completes
   // the run when the count equals the target minus one.
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(int'(settle_cycles) - 1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]   DELAY_LAST  = HOLD_W'(int'(repeat_delay) - 1);
   localparam logic [HOLD_W-1:0]   PERIOD_LAST = HOLD_W'(int'(repeat_period) - 1);
   localparam bit                  SETTLE_IS_ONE = (settle_cycles == 16'd1);

   state_t              state, state_nxt;
   logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic                repeating, repeating_nxt;
   logic                strobe_nxt, release_nxt, pressed_nxt;
   logic                s;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (button),
      .q     (s)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         hold_cnt       <= '0;
         repeating      <= 1'b0;
         strobe         <= 1'b0;
         release_strobe <= 1'b0;
         pressed        <= 1'b0;
      end else begin
         state          <= state_nxt;
         settle_cnt     <= settle_nxt;
         hold_cnt       <= hold_nxt;
         repeating      <= repeating_nxt;
         strobe         <= strobe_nxt;
         release_strobe <= release_nxt;
         pressed        <= pressed_nxt;
      end
   end

   // Next-state, counter updates and strobe decisions.
   always_comb begin
      state_nxt     = state;
      settle_nxt    = settle_cnt;
      hold_nxt      = hold_cnt;
      repeating_nxt = repeating;
      strobe_nxt    = 1'b0;
      release_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (s) begin
               if (SETTLE_IS_ONE) begin
                  state_nxt     = HELD;
                  strobe_nxt    = 1'b1;
                  settle_nxt    = '0;
                  hold_nxt      = '0;
                  repeating_nxt = 1'b0;
               end else begin
                  state_nxt  = SETTLE_PRESS;
                  settle_nxt = SETTLE_ONE;
               end
            end
         end
         SETTLE_PRESS: begin
            if (!s) begin
               state_nxt  = IDLE;
               settle_nxt = '0;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nxt     = HELD;
               strobe_nxt    = 1'b1;
               settle_nxt    = '0;
               hold_nxt      = '0;
               repeating_nxt = 1'b0;
            end else begin
               settle_nxt = settle_cnt + SETTLE_ONE;
            end
         end
         HELD: begin
            if (!s) begin
               if (SETTLE_IS_ONE) begin
                  state_nxt   = IDLE;
                  release_nxt = 1'b1;
                  settle_nxt  = '0;
               end else begin
                  state_nxt  = SETTLE_RELEASE;
                  settle_nxt = SETTLE_ONE;
               end
            end else if (!repeat_enable) begin
               // Re-enabling restarts from the initial repeat delay.
               hold_nxt      = '0;
               repeating_nxt = 1'b0;
            end else if (hold_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
               strobe_nxt    = 1'b1;
               hold_nxt      = '0;
               repeating_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + HOLD_ONE;
            end
         end
         SETTLE_RELEASE: begin
            if (s) begin
               // Release bounce: hold counter resumes where it stopped.
               state_nxt  = HELD;
               settle_nxt = '0;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               settle_nxt  = '0;
            end else begin
               settle_nxt = settle_cnt + SETTLE_ONE;
            end
         end
      endcase
      pressed_nxt = (state_nxt == HELD) || (state_nxt == SETTLE_RELEASE);
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: directed scenarios plus random bouncing,
// checked against a run-length reference model.
module tb_button_debouncer;

   localparam int S  = 4;
   localparam int D  = 20;
   localparam int PD = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic button = 1'b0;
   logic repeat_enable = 1'b0;
   logic strobe, release_strobe, pressed;

   button_debouncer #(
      .settle_cycles (16'(S)),
      .repeat_delay  (24'(D)),
      .repeat_period (24'(PD))
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .button         (button),
      .repeat_enable  (repeat_enable),
      .strobe         (strobe),
      .release_strobe (release_strobe),
      .pressed        (pressed)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct { int stamp; bit rel; } ev_t;
   typedef struct { int stamp; bit lvl; } lv_t;
   ev_t ev_q[$];
   lv_t lv_q[$];
   int  strobe_log[$];
   int  release_log[$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  last_stamp = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic int has_strobe(input int e);
      foreach (strobe_log[i]) if (strobe_log[i] == e) return 1;
      return 0;
   endfunction

   function automatic int has_release(input int e);
      foreach (release_log[i]) if (release_log[i] == e) return 1;
      return 0;
   endfunction

   // Reference model: the debounced level flips once S consecutive synchronised
   // samples disagree with it; repeats fire when the enabled held age hits
   // D, D+PD, D+2*PD, ...
   bit m_s1 = 1'b0, m_s = 1'b0, m_lvl = 1'b0;
   int m_run = 0, m_age = 0;

   task automatic model_step(input bit b, input bit en, input bit rst, input int stamp);
      bit seen;
      seen = m_s;
      if (rst) begin
         m_s1 = 1'b0; m_s = 1'b0; m_lvl = 1'b0; m_run = 0; m_age = 0;
      end else begin
         m_s  = m_s1;
         m_s1 = b;
         if (seen == m_lvl) begin
            if (m_lvl && m_run == 0) begin
               if (!en) m_age = 0;
               else begin
                  m_age++;
                  if (m_age == D || (m_age > D && (m_age - D) % PD == 0))
                     ev_q.push_back(ev_t'{stamp, 1'b0});
               end
            end
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == S) begin
               m_lvl = !m_lvl;
               m_run = 0;
               m_age = 0;
               ev_q.push_back(ev_t'{stamp, !m_lvl});
            end
         end
      end
      lv_q.push_back(lv_t'{stamp, m_lvl});
   endtask

   task automatic step(input bit b, input bit en, input bit rst);
      @(negedge clk);
      #1;
      button        = b;
      repeat_enable = en;
      reset         = rst;
      last_stamp    = edge_n + 1;
      model_step(b, en, rst, last_stamp);
   endtask

   // Monitor: pops expectations and compares against what the DUT shows.
   always @(negedge clk) begin
      ev_t ev;
      lv_t lv;
      if (lv_q.size() > 0 && lv_q[0].stamp == edge_n) begin
         lv = lv_q.pop_front();
         check("pressed", pressed, lv.lvl);
      end
      while (ev_q.size() > 0 && ev_q[0].stamp < edge_n) begin
         ev = ev_q.pop_front();
         n_cmp++; n_fail++;
         $display("FAIL missed_event: got none at edge %0d, expected %s", ev.stamp,
                  ev.rel ? "release_strobe" : "strobe");
      end
      if (strobe || release_strobe) begin
         if (strobe) strobe_log.push_back(edge_n);
         if (release_strobe) release_log.push_back(edge_n);
         if (ev_q.size() > 0 && ev_q[0].stamp == edge_n) begin
            ev = ev_q.pop_front();
            check("event_release", release_strobe, ev.rel);
            check("event_strobe", strobe, !ev.rel);
         end else begin
            n_cmp++; n_fail++;
            $display("FAIL spurious_event: got strobe=%0b release_strobe=%0b at edge %0d, expected none",
                     strobe, release_strobe, edge_n);
         end
      end else if (ev_q.size() > 0 && ev_q[0].stamp == edge_n) begin
         ev = ev_q.pop_front();
         n_cmp++; n_fail++;
         $display("FAIL missed_event: got none at edge %0d, expected %s", edge_n,
                  ev.rel ? "release_strobe" : "strobe");
      end
   end

   task automatic repeat_run(input string name, input int drop, input int exp36);
      int n0, k, p;
      n0 = strobe_log.size();
      step(1'b1, 1'b1, 1'b0);
      k = last_stamp;
      p = k + S + 1;
      while (last_stamp < p + 40) step(1'b1, (last_stamp + 1 < p + drop), 1'b0);
      check({name, "_press"}, has_strobe(p), 1);
      check({name, "_first"}, has_strobe(p + D), 1);
      check({name, "_second"}, has_strobe(p + D + PD), 1);
      check({name, "_third"}, has_strobe(p + D + 2 * PD), exp36);
      check({name, "_count"}, strobe_log.size() - n0, 3 + exp36);
      repeat (15) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1 ms, expected finish");
      $fatal(1);
   end

   initial begin
      int k, n0, r0, r;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("reset_strobe", strobe, 0);
      check("reset_release", release_strobe, 0);
      check("reset_pressed", pressed, 0);

      // Clean press
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n0 = strobe_log.size();
      step(1'b1, 1'b0, 1'b0);
      k = last_stamp;
      repeat (105) step(1'b1, 1'b0, 1'b0);
      check("clean_press_count", strobe_log.size() - n0, 1);
      check("clean_press_edge", has_strobe(k + 5), 1);
      check("clean_press_level", pressed, 1);

      // Release with a one-cycle glitch high
      n0 = strobe_log.size();
      r0 = release_log.size();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      k = last_stamp;
      repeat (20) step(1'b0, 1'b0, 1'b0);
      check("release_count", release_log.size() - r0, 1);
      check("release_edge", has_release(k + 5), 1);
      check("release_no_strobe", strobe_log.size() - n0, 0);
      check("release_level", pressed, 0);

      // Bounce rejection on press
      n0 = strobe_log.size();
      for (int i = 0; i < 8; i++) step(((i / 2) % 2) == 0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      k = last_stamp;
      repeat (30) step(1'b1, 1'b0, 1'b0);
      check("bounce_count", strobe_log.size() - n0, 1);
      check("bounce_edge", has_strobe(k + 5), 1);
      repeat (20) step(1'b0, 1'b0, 1'b0);

      // Auto-repeat held, then with enable dropped at P+30
      repeat_run("repeat_held", 1000, 1);
      repeat_run("repeat_drop", 30, 0);

      // Reset two cycles into the press settle, button held across reset release
      n0 = strobe_log.size();
      step(1'b1, 1'b0, 1'b0);
      k = last_stamp;
      while (last_stamp < k + 3) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("midsettle_pressed", pressed, 0);
      check("midsettle_strobe", strobe, 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      r = last_stamp;
      repeat (12) step(1'b1, 1'b0, 1'b0);
      check("held_reset_count", strobe_log.size() - n0, 1);
      check("held_reset_edge", has_strobe(r + 5), 1);
      repeat (15) step(1'b0, 1'b0, 1'b0);

      // Random bouncing, dwell times, enable toggles and occasional resets
      begin
         bit en;
         en = 1'b1;
         for (int seg = 0; seg < 300; seg++) begin
            bit lvl;
            int dwell;
            lvl   = 1'($urandom_range(0, 1));
            dwell = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 60))
                                                : int'($urandom_range(1, 6));
            if ($urandom_range(0, 60) == 0) begin
               repeat ($urandom_range(1, 3)) step(lvl, en, 1'b1);
            end
            for (int c = 0; c < dwell; c++) begin
               if ($urandom_range(0, 19) == 0) en = !en;
               step(lvl, en, 1'b0);
            end
         end
      end

      repeat (20) step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("event_queue_drained", ev_q.size(), 0);
      check("level_queue_drained", lv_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
